// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequencer for the glitch-free clk1/clk2 clock mux.
// Takes switch requests over valid/ready and drives the registered mux select.
// Each hand-over is confirmed from the mux's synchronised gate-enable status,
// with a timeout on each phase. It also tracks clk2 liveness from a heartbeat
// toggle. All logic runs on clk1, which is always running.
module clk_switch_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int SYNC_STAGES = 2,
    parameter int HB_WINDOW   = 32
) (
    input  logic       clk1,
    input  logic       rstn,
    input  logic       req_valid,
    input  logic       req_src,
    output logic       req_ready,
    output logic       mux_sel,
    input  logic       en1_async,
    input  logic       en2_async,
    input  logic       clk2_hb,
    output logic       cur_src,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       clk2_ok
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int HW = $clog2(HB_WINDOW + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [HW-1:0] HB_MAX     = HW'(HB_WINDOW);
    localparam logic [HW-1:0] HB_LAST    = HW'(HB_WINDOW - 1);

    logic [1:0]             state;
    logic                   target;
    logic [TW-1:0]          timer;
    logic [SYNC_STAGES-1:0] en1_sr;
    logic [SYNC_STAGES-1:0] en2_sr;
    logic [SYNC_STAGES-1:0] hb_sr;
    logic                   hb_prev;
    logic [HW-1:0]          hb_cnt;

    logic en1_s;
    logic en2_s;
    logic hb_s;
    logic hb_edge;
    logic old_en;
    logic new_en;

    assign en1_s   = en1_sr[SYNC_STAGES-1];
    assign en2_s   = en2_sr[SYNC_STAGES-1];
    assign hb_s    = hb_sr[SYNC_STAGES-1];
    assign hb_edge = hb_s ^ hb_prev;

    // The gate we wait to close is the source being left; the one we wait to open is the target.
    assign old_en = target ? en1_s : en2_s;
    assign new_en = target ? en2_s : en1_s;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Bring the asynchronous mux status and heartbeat into the clk1 domain.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            en1_sr  <= '0;
            en2_sr  <= '0;
            hb_sr   <= '0;
            hb_prev <= 1'b0;
        end else begin
            en1_sr  <= {en1_sr[SYNC_STAGES-2:0], en1_async};
            en2_sr  <= {en2_sr[SYNC_STAGES-2:0], en2_async};
            hb_sr   <= {hb_sr[SYNC_STAGES-2:0], clk2_hb};
            hb_prev <= hb_s;
        end
    end

    // Heartbeat watchdog: any toggle marks clk2 alive; HB_WINDOW quiet cycles mark it dead.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            hb_cnt  <= '0;
            clk2_ok <= 1'b0;
        end else if (hb_edge) begin
            hb_cnt  <= '0;
            clk2_ok <= 1'b1;
        end else if (hb_cnt != HB_MAX) begin
            hb_cnt <= hb_cnt + 1'b1;
            if (hb_cnt == HB_LAST) begin
                clk2_ok <= 1'b0;
            end
        end
    end

    // Switch sequencer: accept, drain old gate, arm new gate, confirm.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            target   <= 1'b0;
            timer    <= '0;
            cur_src  <= 1'b0;
            mux_sel  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        err_code <= 2'b00;
                        target   <= req_src;
                        if (req_src == cur_src) begin
                            // Already on the requested source: confirm without touching the mux.
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else if (req_src && !clk2_ok) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            mux_sel <= ~req_src;
                            state   <= S_DRAIN;
                            timer   <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!old_en) begin
                        state <= S_ARM;
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        // Old gate never closed: put the select back on the source still running.
                        mux_sel  <= ~cur_src;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ARM: begin
                    if (new_en) begin
                        state   <= S_FIN;
                        done    <= 1'b1;
                        cur_src <= target;
                    end else if (timer == TIMER_LAST) begin
                        // Old gate is already closed, so the target is the only candidate left.
                        cur_src  <= target;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: hand-computed expectations checked
// with immediate assertions, plus a free-running clk2 heartbeat toggle.
module tb_clk_switch_ctrl;

    logic       clk1;
    logic       rstn;
    logic       req_valid;
    logic       req_src;
    logic       req_ready;
    logic       mux_sel;
    logic       en1_async;
    logic       en2_async;
    logic       clk2_hb;
    logic       cur_src;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       clk2_ok;

    logic hb_run;
    int   n_checks;
    int   n_errors;
    int   nd;
    int   ne;

    clk_switch_ctrl #(
        .TIMEOUT_CYC(64),
        .SYNC_STAGES(2),
        .HB_WINDOW  (32)
    ) dut (
        .clk1     (clk1),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_src  (req_src),
        .req_ready(req_ready),
        .mux_sel  (mux_sel),
        .en1_async(en1_async),
        .en2_async(en2_async),
        .clk2_hb  (clk2_hb),
        .cur_src  (cur_src),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .clk2_ok  (clk2_ok)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // clk2-domain heartbeat, toggling on an unrelated 7 ns period while hb_run is set
    initial begin
        clk2_hb = 1'b0;
        forever begin
            #7;
            if (hb_run) clk2_hb = ~clk2_hb;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge; caller guarantees IDLE.
    task automatic do_req(input logic src);
        req_valid = 1'b1;
        req_src   = src;
        tick();
        req_valid = 1'b0;
    endtask

    // Run until the sequencer returns to IDLE, counting done/err pulses on the way.
    task automatic run_until_idle(input int max, output int d_cnt, output int e_cnt);
        d_cnt = 0;
        e_cnt = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done) d_cnt++;
            if (err) e_cnt++;
            if (!busy) break;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mux_sel"},   32'(mux_sel),   32'd1);
        chk({tag, "_cur_src"},   32'(cur_src),   32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
        chk({tag, "_err_code"},  32'(err_code),  32'd0);
        chk({tag, "_clk2_ok"},   32'(clk2_ok),   32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_src   = 1'b0;
        en1_async = 1'b1;
        en2_async = 1'b0;
        hb_run    = 1'b1;

        // Reset state
        tick();
        tick();
        chk_reset_vals("rst");
        rstn = 1'b1;
        repeat (10) tick();
        chk("t1_clk2_ok", 32'(clk2_ok), 32'd1);

        // Test 1: switch clk1 -> clk2 with healthy handshake
        do_req(1'b1);
        chk("t1_mux_sel_n1", 32'(mux_sel),   32'd0);
        chk("t1_busy_n1",    32'(busy),      32'd1);
        chk("t1_ready_n1",   32'(req_ready), 32'd0);
        chk("t1_done_n1",    32'(done),      32'd0);
        repeat (3) tick();
        chk("t1_drain_busy", 32'(busy), 32'd1);
        en1_async = 1'b0;
        en2_async = 1'b1;
        run_until_idle(20, nd, ne);
        chk("t1_done_cnt", 32'(nd),      32'd1);
        chk("t1_err_cnt",  32'(ne),      32'd0);
        chk("t1_cur_src",  32'(cur_src), 32'd1);
        chk("t1_mux_sel",  32'(mux_sel), 32'd0);
        chk("t1_ready",    32'(req_ready), 32'd1);

        // Test 5: request the source already active
        do_req(1'b1);
        chk("t5_done_n1",  32'(done),      32'd1);
        chk("t5_busy_n1",  32'(busy),      32'd1);
        chk("t5_mux_n1",   32'(mux_sel),   32'd0);
        chk("t5_err_n1",   32'(err),       32'd0);
        tick();
        chk("t5_done_n2",  32'(done),      32'd0);
        chk("t5_busy_n2",  32'(busy),      32'd0);
        chk("t5_ready_n2", 32'(req_ready), 32'd1);

        // Return to clk1 so the dead-clk2 request below is a real switch attempt
        do_req(1'b0);
        chk("back_mux_n1", 32'(mux_sel), 32'd1);
        en2_async = 1'b0;
        en1_async = 1'b1;
        run_until_idle(20, nd, ne);
        chk("back_done_cnt", 32'(nd),      32'd1);
        chk("back_cur_src",  32'(cur_src), 32'd0);

        // Test 2: clk2 heartbeat stops, request clk2
        hb_run = 1'b0;
        repeat (45) tick();
        chk("t2_clk2_ok", 32'(clk2_ok), 32'd0);
        do_req(1'b1);
        chk("t2_err_n1",  32'(err),       32'd1);
        chk("t2_code_n1", 32'(err_code),  32'd1);
        chk("t2_done_n1", 32'(done),      32'd0);
        chk("t2_mux_n1",  32'(mux_sel),   32'd1);
        chk("t2_busy_n1", 32'(busy),      32'd0);
        tick();
        chk("t2_err_n2",  32'(err),       32'd0);
        chk("t2_code_n2", 32'(err_code),  32'd1);

        // Test 3: en1 stuck high, drain timeout after 64 DRAIN cycles
        hb_run = 1'b1;
        repeat (10) tick();
        chk("t3_clk2_ok", 32'(clk2_ok), 32'd1);
        do_req(1'b1);
        chk("t3_mux_n1",  32'(mux_sel),  32'd0);
        chk("t3_code_n1", 32'(err_code), 32'd0);
        repeat (63) tick();
        chk("t3_err_pre",  32'(err),  32'd0);
        chk("t3_busy_pre", 32'(busy), 32'd1);
        chk("t3_mux_pre",  32'(mux_sel), 32'd0);
        tick();
        chk("t3_err",     32'(err),      32'd1);
        chk("t3_code",    32'(err_code), 32'd2);
        chk("t3_mux",     32'(mux_sel),  32'd1);
        chk("t3_cur_src", 32'(cur_src),  32'd0);
        chk("t3_busy",    32'(busy),     32'd0);
        chk("t3_done",    32'(done),     32'd0);
        tick();
        chk("t3_err_post", 32'(err), 32'd0);

        // Test 4: drain completes, en2 never rises -> arm timeout
        en1_async = 1'b0;
        repeat (3) tick();
        do_req(1'b1);
        repeat (64) tick();
        chk("t4_err_pre",  32'(err),  32'd0);
        chk("t4_busy_pre", 32'(busy), 32'd1);
        tick();
        chk("t4_err",     32'(err),      32'd1);
        chk("t4_code",    32'(err_code), 32'd3);
        chk("t4_cur_src", 32'(cur_src),  32'd1);
        chk("t4_mux",     32'(mux_sel),  32'd0);
        chk("t4_busy",    32'(busy),     32'd0);
        chk("t4_done",    32'(done),     32'd0);

        // Test 6: reset asserted while in ARM
        do_req(1'b0);
        repeat (5) tick();
        chk("t6_busy_arm", 32'(busy),    32'd1);
        chk("t6_mux_arm",  32'(mux_sel), 32'd1);
        rstn = 1'b0;
        #1;
        chk_reset_vals("t6");
        nd = 0;
        ne = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) nd++;
            if (err) ne++;
        end
        chk("t6_done_in_rst", 32'(nd), 32'd0);
        chk("t6_err_in_rst",  32'(ne), 32'd0);
        en1_async = 1'b1;
        en2_async = 1'b0;
        rstn = 1'b1;
        repeat (10) tick();
        chk("t6_clk2_ok", 32'(clk2_ok), 32'd1);
        do_req(1'b1);
        chk("t6_mux_n1",  32'(mux_sel), 32'd0);
        chk("t6_busy_n1", 32'(busy),    32'd1);
        en1_async = 1'b0;
        en2_async = 1'b1;
        run_until_idle(20, nd, ne);
        chk("t6_done_cnt", 32'(nd),      32'd1);
        chk("t6_err_cnt",  32'(ne),      32'd0);
        chk("t6_cur_src",  32'(cur_src), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
